gate_test_sequencer: RTL and testbench
======================================

# gate_test_sequencer

Self-checking stimulus controller for the basic logic gates. It walks every input pattern of a WIDTH-bit gate-under-test, lets each pattern settle, samples the gate output, and compares it against the gate's golden function. Mismatches are counted and the first failing vector is captured. It sits beside any gate in the basic-components library (NOT first) and replaces hand-written per-gate stimulus blocks with one clocked sequencer driven by start/done.

## Interface
- `WIDTH`, default 1: gate input/output width; exhaustive sweep covers 2^WIDTH vectors (1..8 supported).
- `SETTLE`, default 1: wait cycles between applying a vector and sampling (0..15).
- `OP`, default 0 (`OP_NOT`): golden function; `OP_NOT`: expected = ~a; `OP_BUF`: expected = a.
- `ERR_W`, default 8: error counter width.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a sweep; sampled only in IDLE.
- `abort`, in, 1: cancel a running sweep.
- `dut_a`, out, WIDTH: registered stimulus to the gate input.
- `dut_y`, in, WIDTH: gate output.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at sweep completion.
- `pass`, out, 1: sweep finished with err_count==0; held until next start.
- `err_count`, out, ERR_W: mismatching vectors, saturating at 2^ERR_W-1.
- `first_fail`, out, WIDTH: dut_a value of the first mismatch.
- `first_fail_valid`, out, 1: first_fail holds a captured value.

## Operation
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE: start=1 and abort=0 -> clear err_count, pass, first_fail, first_fail_valid; vector index=0; go APPLY.
- APPLY (1 cycle): dut_a = index. Next WAIT if SETTLE>0, else CHECK.
- WAIT: down-counter loaded with SETTLE-1 on entry; leave to CHECK when it reaches 0 (exactly SETTLE cycles).
- CHECK (1 cycle): compare dut_y with expected(dut_a) across all WIDTH bits. On mismatch: err_count++ (saturating); if !first_fail_valid, capture first_fail=dut_a and set first_fail_valid. Then if index==2^WIDTH-1 go DONE, else index+1, go APPLY.
- DONE (1 cycle): done=1; pass = (err_count==0), computed including the final CHECK result; go IDLE.
- abort=1 in APPLY/WAIT/CHECK/DONE: IDLE next cycle, no done pulse, pass stays 0, err_count/first_fail keep partial values, dut_a returns to 0.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Index counter is WIDTH+1 bits internally so 2^WIDTH-1 never wraps to 0 before the end test.

## Timing
- Reset values: state IDLE, dut_a 0, busy 0, done 0, pass 0, err_count 0, first_fail 0, first_fail_valid 0.
- Reset mid-sweep: immediate return to reset values, asynchronously.
- Cycles per vector: 2+SETTLE. start sampled at edge T -> APPLY for vector 0 in cycle T+1 -> done high in cycle T+1+2^WIDTH*(2+SETTLE).
- dut_y is sampled at the rising edge ending CHECK, SETTLE+1 edges after dut_a changed.
- busy falls in the same cycle done falls. A new start is accepted in the first IDLE cycle after DONE.

## Structure
- Package `gate_seq_pkg`: state enum `gate_seq_state_t`, op constants `OP_NOT=0` and `OP_BUF=1`, max WIDTH/SETTLE limits.
- Sub-module `gate_seq_expected`: combinational golden model, (OP, a) -> expected y. Future gates (AND/OR/XOR reductions) extend only this module and the package.
- Top: FSM, index counter, settle counter, error counter, and capture registers.

## Test plan
- NOT gate, WIDTH=1, SETTLE=1, start at T: dut_a goes 0 then 1; done in cycle T+7; pass=1, err_count=0, first_fail_valid=0.
- Gate replaced by buffer (y=a), OP_NOT: err_count=2, first_fail=0, first_fail_valid=1, pass=0.
- WIDTH=3, SETTLE=0, output bit 1 stuck at 0: 8 vectors, done in cycle T+17; err_count=4 (vectors 0,1,4,5), first_fail=3'b000.
- ERR_W=2, WIDTH=3, all vectors wrong: err_count saturates at 3; pass=0.
- abort in WAIT of vector 1 (WIDTH=2): IDLE next cycle, no done pulse, busy=0, dut_a=0. A new start gives a clean full sweep.
- rst_n low during CHECK: all outputs return to reset values immediately. start pulsed while busy: no restart, done timing unchanged.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and limits for the gate test sequencer.
// Golden-function selectors and sweep limits live here.
package gate_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } gate_seq_state_t;

  localparam int OP_NOT     = 0;
  localparam int OP_BUF     = 1;
  localparam int MAX_WIDTH  = 8;
  localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/gate_seq_expected.sv
// Combinational golden model of the gate under test.
// New gate kinds extend only this module and the package.
module gate_seq_expected
  import gate_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int OP    = OP_NOT
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (1'b1)
      (OP == OP_BUF): y_o = a_i;
      default:        y_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus/compare sequencer for a WIDTH-bit gate.
// Walks all 2^WIDTH vectors, counts mismatches, keeps the first.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int OP     = OP_NOT,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_fail,
  output logic             first_fail_valid
);

  localparam logic [WIDTH:0] IDX_LAST = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] IDX_ONE  = (WIDTH+1)'(1);
  localparam logic [3:0]     SET_M1   = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  gate_seq_state_t  state_q, state_d;
  logic [WIDTH:0]   idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] y_exp;
  logic             mism;

  gate_seq_expected #(
    .WIDTH (WIDTH),
    .OP    (OP)
  ) u_exp (
    .a_i (a_q),
    .y_o (y_exp)
  );

  assign mism = (dut_y != y_exp);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    // abort freezes results and parks the stimulus at 0
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      a_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            err_d   = '0;
            pass_d  = 1'b0;
            ff_d    = '0;
            ffv_d   = 1'b0;
            idx_d   = '0;
            state_d = S_APPLY;
          end
        end
        S_APPLY: begin
          a_d     = idx_q[WIDTH-1:0];
          cnt_d   = SET_M1;
          state_d = (SETTLE > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_d = S_CHECK;
          else cnt_d = cnt_q - 4'd1;
        end
        S_CHECK: begin
          if (mism) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
            if (!ffv_q) begin
              ff_d  = a_q;
              ffv_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_APPLY;
          end
        end
        S_DONE: begin
          pass_d  = (err_q == '0);
          a_d     = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a            = a_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE) && !abort;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench: three sequencer configurations against a sweep-level model.
// Gate faults are injected through per-vector xor masks.
module tb_gate_test_sequencer;

  localparam int W[3]  = '{1, 3, 2};
  localparam int S[3]  = '{1, 0, 3};
  localparam int EW[3] = '{8, 3, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st[3];
  logic ab[3];
  logic [7:0] mask [3][8];

  logic [0:0] a0, y0, f0;
  logic [2:0] a1, y1, f1;
  logic [1:0] a2, y2, f2;
  logic [7:0] e0;
  logic [2:0] e1;
  logic [3:0] e2;
  logic b0, b1, b2, d0, d1, d2, p0, p1, p2, v0, v1, v2;

  // gate models: NOT, NOT, BUF, each with an injected fault mask
  assign y0 = ~a0 ^ mask[0][a0][0:0];
  assign y1 = ~a1 ^ mask[1][a1][2:0];
  assign y2 = a2 ^ mask[2][a2][1:0];

  gate_test_sequencer #(.WIDTH(1), .SETTLE(1), .OP(0), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
    .dut_a(a0), .dut_y(y0), .busy(b0), .done(d0), .pass(p0),
    .err_count(e0), .first_fail(f0), .first_fail_valid(v0));

  gate_test_sequencer #(.WIDTH(3), .SETTLE(0), .OP(0), .ERR_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
    .dut_a(a1), .dut_y(y1), .busy(b1), .done(d1), .pass(p1),
    .err_count(e1), .first_fail(f1), .first_fail_valid(v1));

  gate_test_sequencer #(.WIDTH(2), .SETTLE(3), .OP(1), .ERR_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(ab[2]),
    .dut_a(a2), .dut_y(y2), .busy(b2), .done(d2), .pass(p2),
    .err_count(e2), .first_fail(f2), .first_fail_valid(v2));

  always #5 clk = ~clk;

  logic [7:0] oa[3], oerr[3], off[3];
  logic obusy[3], odone[3], opass[3], offv[3];
  assign oa[0] = {7'd0, a0};
  assign oa[1] = {5'd0, a1};
  assign oa[2] = {6'd0, a2};
  assign oerr[0] = e0;
  assign oerr[1] = {5'd0, e1};
  assign oerr[2] = {4'd0, e2};
  assign off[0] = {7'd0, f0};
  assign off[1] = {5'd0, f1};
  assign off[2] = {6'd0, f2};
  assign obusy = '{b0, b1, b2};
  assign odone = '{d0, d1, d2};
  assign opass = '{p0, p1, p2};
  assign offv  = '{v0, v1, v2};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int i,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t",
               nm, i, act, exp, $time);
    end
  endtask

  function automatic int nv(int i);
    return 1 << W[i];
  endfunction
  function automatic int ln(int i);
    return 2 + S[i];
  endfunction
  function automatic int emax(int i);
    return (1 << EW[i]) - 1;
  endfunction

  // sweep-level model: position p counts cycles since the sweep began
  bit m_act[3];
  int m_p[3], m_err[3], m_ff[3];
  bit m_ffv[3], m_pass[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= 0; m_p[i] <= 0; m_err[i] <= 0;
        m_ff[i] <= 0; m_ffv[i] <= 0; m_pass[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_act[i]) begin
          if (st[i] && !ab[i]) begin
            m_act[i] <= 1; m_p[i] <= 0; m_err[i] <= 0;
            m_ff[i] <= 0; m_ffv[i] <= 0; m_pass[i] <= 0;
          end
        end else if (ab[i]) begin
          m_act[i] <= 0;
        end else if (m_p[i] == nv(i) * ln(i)) begin
          m_act[i] <= 0;
          m_pass[i] <= (m_err[i] == 0);
        end else begin
          if ((m_p[i] % ln(i)) == ln(i) - 1 &&
              mask[i][m_p[i] / ln(i)] != 8'd0) begin
            if (m_err[i] < emax(i)) m_err[i] <= m_err[i] + 1;
            if (!m_ffv[i]) begin
              m_ff[i] <= m_p[i] / ln(i);
              m_ffv[i] <= 1;
            end
          end
          m_p[i] <= m_p[i] + 1;
        end
      end
    end
  end

  function automatic int exp_a(int i);
    int v, ph;
    if (!m_act[i]) return 0;
    if (m_p[i] == nv(i) * ln(i)) return nv(i) - 1;
    v = m_p[i] / ln(i);
    ph = m_p[i] % ln(i);
    if (ph == 0) return (v == 0) ? 0 : v - 1;
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, int'(obusy[i]), int'(m_act[i]));
      chk("done", i, int'(odone[i]),
          int'(m_act[i] && m_p[i] == nv(i) * ln(i) && !ab[i]));
      chk("dut_a", i, int'(oa[i]), exp_a(i));
      chk("err_count", i, int'(oerr[i]), m_err[i]);
      chk("first_fail", i, int'(off[i]), m_ff[i]);
      chk("ff_valid", i, int'(offv[i]), int'(m_ffv[i]));
      chk("pass", i, int'(opass[i]), int'(m_pass[i]));
    end
  end

  task automatic set_mask(input int i, input int mode);
    for (int v = 0; v < 8; v++) begin
      logic [7:0] wm;
      wm = 8'((1 << W[i]) - 1);
      unique case (mode)
        0: mask[i][v] = 8'd0;
        1: mask[i][v] = wm;
        2: mask[i][v] = (v[1] == 1'b0) ? 8'd2 : 8'd0;
        3: mask[i][v] = 8'($urandom_range(1, 255)) & wm;
        default: mask[i][v] = ($urandom_range(0, 1) == 0) ? 8'd0
                              : 8'($urandom) & wm;
      endcase
      if (mode == 3 && mask[i][v] == 8'd0) mask[i][v] = 8'd1;
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk); #1 st[i] = 1;
    @(posedge clk); #1 st[i] = 0;
  endtask

  // lat: cycles from the start edge to the done cycle
  task automatic sweep(input int i, input int restart_at,
                       output int lat);
    lat = 0;
    pulse_start(i);
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (odone[i]) begin
        lat = k;
        break;
      end
      if (k == restart_at) #1 st[i] = 1;
      if (k == restart_at + 1) #1 st[i] = 0;
    end
    if (lat == 0) chk("done_timeout", i, 0, 1);
  endtask

  task automatic wait_pos(input int i, input int pos);
    bit hit;
    hit = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_act[i] && m_p[i] == pos) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("pos_timeout", i, 0, 1);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; ab[i] = 0;
      set_mask(i, 0);
    end
    #23;
    chk("rst_busy", 0, int'(b0), 0);
    chk("rst_a", 1, int'(a1), 0);
    @(negedge clk); #1 rst_n = 1;

    // healthy NOT gate
    sweep(0, 0, lat);
    chk("lat_w1s1", 0, lat, 7);
    chk("err_good", 0, int'(e0), 0);
    chk("ffv_good", 0, int'(v0), 0);
    @(negedge clk);
    chk("pass_good", 0, int'(p0), 1);

    // buffer in place of NOT
    set_mask(0, 1);
    sweep(0, 0, lat);
    chk("err_buf", 0, int'(e0), 2);
    chk("ff_buf", 0, int'(f0), 0);
    chk("ffv_buf", 0, int'(v0), 1);
    @(negedge clk);
    chk("pass_buf", 0, int'(p0), 0);

    // bit 1 stuck at 0
    set_mask(1, 2);
    sweep(1, 0, lat);
    chk("lat_w3s0", 1, lat, 17);
    chk("err_stuck", 1, int'(e1), 4);
    chk("ff_stuck", 1, int'(f1), 0);

    // every vector wrong: saturate at 7
    set_mask(1, 3);
    sweep(1, 0, lat);
    chk("err_sat", 1, int'(e1), 7);
    @(negedge clk);
    chk("pass_sat", 1, int'(p1), 0);

    // abort in WAIT of vector 1
    set_mask(2, 1);
    pulse_start(2);
    wait_pos(2, 7);
    #1 ab[2] = 1;
    @(posedge clk); #1 ab[2] = 0;
    @(negedge clk);
    chk("abort_busy", 2, int'(b2), 0);
    chk("abort_a", 2, int'(a2), 0);
    chk("abort_err", 2, int'(e2), 1);
    set_mask(2, 0);
    sweep(2, 0, lat);
    chk("lat_w2s3", 2, lat, 21);
    chk("err_clean", 2, int'(e2), 0);

    // reset while in CHECK of vector 1
    set_mask(2, 1);
    pulse_start(2);
    wait_pos(2, 9);
    #2 rst_n = 0;
    #1;
    chk("rst_busy", 2, int'(b2), 0);
    chk("rst_a", 2, int'(a2), 0);
    chk("rst_err", 2, int'(e2), 0);
    chk("rst_ffv", 2, int'(v2), 0);
    @(negedge clk); #1 rst_n = 1;

    // start while busy is ignored
    set_mask(0, 0);
    sweep(0, 3, lat);
    chk("lat_restart", 0, lat, 7);

    // random traffic on all instances
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!m_act[i] && !st[i]) set_mask(i, 4);
        st[i] = ($urandom_range(0, 5) == 0);
        ab[i] = ($urandom_range(0, 60) == 0);
      end
    end
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; ab[i] = 0;
    end
    repeat (60) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
